pls_cnt_mod: RTL

Parametrised modulo-N pulse counter for the watch datapath (seconds/minutes/hundredths chains). Synchronises an asynchronous pulse input and an asynchronous clear, then counts the selected edge up or down modulo MOD. Provides a square-wave carry (plso), a one-cycle terminal-count pulse (tc) for cascading, and synchronous preset load and count enable for time setting.

---
 rtl/pls_cnt_mod_pkg.sv | 8 +
 rtl/pls_cnt_mod_if.sv | 15 +
 rtl/pls_cnt_mod_sync_edge_det.sv | 28 ++
 rtl/pls_cnt_mod.sv | 54 +++++
 4 files changed

// File: rtl/pls_cnt_mod_pkg.sv
// pls_cnt_pkg: shared constants for the watch-datapath modulo-N pulse counter chains
//   EDGE_FALL/EDGE_RISE select the counted plsi edge, DIR_UP/DIR_DN encode dir
package pls_cnt_pkg;
   localparam int   EDGE_FALL = 0;
   localparam int   EDGE_RISE = 1;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DN    = 1'b1;
endpackage

// File: rtl/pls_cnt_mod_if.sv
// pls_cnt_mod_if: control/data bundle of one pulse counter stage
//   master drives clr, plsi, en, dir, ld, din; slave (the counter) drives qout, plso, tc
interface pls_cnt_mod_if #(parameter int W = 7);
   logic         clr;
   logic         plsi;
   logic         en;
   logic         dir;
   logic         ld;
   logic [W-1:0] din;
   logic [W-1:0] qout;
   logic         plso;
   logic         tc;
   modport master (output clr, plsi, en, dir, ld, din, input qout, plso, tc);
   modport slave  (input clr, plsi, en, dir, ld, din, output qout, plso, tc);
endinterface

// File: rtl/pls_cnt_mod_sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser plus edge-history flop for one async input
//   rst  async active-low reset, clk system clock, d async input
//   rise/fall one-cycle pulses on the synchronised rising/falling edge of d
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic rst,
   input  logic clk,
   input  logic d,
   output logic rise,
   output logic fall
);
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_edge_det: SYNC_STAGES must be >= 2");
   end
   logic [SYNC_STAGES-1:0] s;
   logic                   h;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         s <= '0;
         h <= 1'b0;
      end else begin
         s <= {s[SYNC_STAGES-2:0], d};
         h <= s[SYNC_STAGES-1];
      end
   assign rise = s[SYNC_STAGES-1] & ~h;
   assign fall = ~s[SYNC_STAGES-1] & h;
endmodule

// File: rtl/pls_cnt_mod.sv
// pls_cnt_mod: modulo-MOD up/down pulse counter with preset load, square carry and wrap pulse
//   rst  async active-low reset, clk system clock
//   bus  pls_cnt_mod_if.slave: clr/plsi async inputs, en/dir/ld/din sync controls,
//        qout count, plso = (qout >= MOD/2), tc one-cycle wrap pulse; all outputs registered
module pls_cnt_mod
   import pls_cnt_pkg::*;
#(
   parameter int MOD         = 100,
   parameter int W           = 7,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE        = 0
) (
   input logic           rst,
   input logic           clk,
   pls_cnt_mod_if.slave  bus
);
   if (MOD < 2 || MOD > 2**W) begin : g_bad_mod
      $error("pls_cnt_mod: MOD must satisfy 2 <= MOD <= 2**W");
   end
   if (EDGE != EDGE_FALL && EDGE != EDGE_RISE) begin : g_bad_edge
      $error("pls_cnt_mod: EDGE must be 0 or 1");
   end
   localparam logic [W-1:0] TOP  = W'(MOD - 1);
   localparam logic [W-1:0] HALF = W'(MOD / 2);
   logic         p_rise, p_fall, c_rise;
   logic         cnt_ev, wrap, ntc;
   logic [W-1:0] q, step, ld_v, nq;
   logic         plso_r, tc_r;
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_pls (
      .rst(rst), .clk(clk), .d(bus.plsi), .rise(p_rise), .fall(p_fall));
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
      .rst(rst), .clk(clk), .d(bus.clr), .rise(c_rise), .fall());
   assign cnt_ev = bus.en & (EDGE == EDGE_RISE ? p_rise : p_fall);
   assign wrap   = bus.dir == DIR_DN ? q == '0 : q == TOP;
   assign step   = bus.dir == DIR_DN ? (wrap ? TOP : q - 1'b1) : (wrap ? '0 : q + 1'b1);
   assign ld_v   = bus.din > TOP ? TOP : bus.din;
   // clear beats load beats count; a dropped event simply never happened
   assign nq     = c_rise ? '0 : bus.ld ? ld_v : cnt_ev ? step : q;
   assign ntc    = ~c_rise & ~bus.ld & cnt_ev & wrap;
   // plso comes from the next count so it is registered in step with qout
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         q      <= '0;
         plso_r <= 1'b0;
         tc_r   <= 1'b0;
      end else begin
         q      <= nq;
         plso_r <= nq >= HALF;
         tc_r   <= ntc;
      end
   assign bus.qout = q;
   assign bus.plso = plso_r;
   assign bus.tc   = tc_r;
endmodule
